// File: rtl/apb_master_queued.sv
// apb_master_queued: APB4 requester fed by a command FIFO.
// Commands are pushed on a valid/ready port, executed as SETUP/ACCESS
// sequences to one of NO_SLAVES completers (index-based select), and each
// produces exactly one single-cycle response pulse. Queued commands run
// back-to-back without an IDLE gap, and a PREADY watchdog aborts stuck
// transfers.
module apb_master_queued #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int NO_SLAVES  = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16,
  localparam int BYTES_PER_WORD = DATA_WIDTH / 8,
  localparam int SEL_W = (NO_SLAVES > 1) ? $clog2(NO_SLAVES) : 1,
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                      pclk,
  input  logic                      preset_n,
  // command port
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [2:0]                cmd_prot,
  input  logic [SEL_W-1:0]          cmd_sel,
  input  logic                      cmd_write,
  input  logic [DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [BYTES_PER_WORD-1:0] cmd_strb,
  // response and status
  output logic                      rsp_valid,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic                      rsp_error,
  output logic                      rsp_timeout,
  output logic [CNT_W-1:0]          queue_count,
  // APB side
  output logic [ADDR_WIDTH-1:0]     paddr,
  output logic [2:0]                pprot,
  output logic [NO_SLAVES-1:0]      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [DATA_WIDTH-1:0]     pwdata,
  output logic [BYTES_PER_WORD-1:0] pstrb,
  input  logic                      pready,
  input  logic [DATA_WIDTH-1:0]     prdata,
  input  logic                      pslverr
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]     addr;
    logic [2:0]                prot;
    logic [SEL_W-1:0]          sel;
    logic                      write;
    logic [DATA_WIDTH-1:0]     wdata;
    logic [BYTES_PER_WORD-1:0] strb;
  } cmd_t;

  cmd_t                 mem [FIFO_DEPTH];
  cmd_t                 head;
  cmd_t                 push_entry;
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;
  logic [1:0]           state;
  logic [WAIT_W-1:0]    wait_cnt;
  logic                 push;
  logic                 pop;
  logic                 start;
  logic                 dec_err;
  logic                 head_ok;
  logic                 done;
  logic                 timeout_hit;
  logic [NO_SLAVES-1:0] head_onehot;

  // Ready comes from the registered count only, so a pop in the same cycle
  // never frees a slot for a push into a full queue.
  assign cmd_ready   = (count != CNT_W'(FIFO_DEPTH));
  assign queue_count = count;
  assign push        = cmd_valid && cmd_ready;
  assign head        = mem[rd_ptr];
  assign push_entry  = '{addr: cmd_addr, prot: cmd_prot, sel: cmd_sel,
                         write: cmd_write, wdata: cmd_wdata, strb: cmd_strb};

  // Decide whether the head is popped this cycle and what it turns into.
  // NOTE: combinational blocks use blocking '=' and give every output a
  // default before any condition, so no latch can be inferred.
  always_comb begin
    head_onehot = '0;
    for (int i = 0; i < NO_SLAVES; i++) begin
      head_onehot[i] = (int'(head.sel) == i);
    end
    head_ok     = (int'(head.sel) < NO_SLAVES);
    timeout_hit = (TIMEOUT != 0) && !pready && (int'(wait_cnt) == TIMEOUT - 1);
    done        = (state == ST_ACCESS) && (pready || timeout_hit);
    // A decode-error head behind a finishing transfer waits for IDLE so two
    // responses never coincide.
    start       = (count != '0) && head_ok && ((state == ST_IDLE) || done);
    dec_err     = (state == ST_IDLE) && (count != '0) && !head_ok;
    pop         = start || dec_err;
  end

  // Queue storage write port.
  // NOTE: the storage array has no reset; validity is tracked by the
  // pointers and count, which are reset.
  always_ff @(posedge pclk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  // Queue pointers and occupancy; pointers wrap naturally (depth is 2^n).
  // NOTE: sequential state uses non-blocking '<=' throughout.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // APB sequencer: IDLE -> SETUP -> ACCESS, with back-to-back chaining,
  // watchdog abort and response generation.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state       <= ST_IDLE;
      psel        <= '0;
      penable     <= 1'b0;
      paddr       <= '0;
      pprot       <= '0;
      pwrite      <= 1'b0;
      pwdata      <= '0;
      pstrb       <= '0;
      wait_cnt    <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_error   <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;

      if (state == ST_ACCESS) begin
        if (pready) begin
          rsp_valid   <= 1'b1;
          rsp_error   <= pslverr;
          rsp_timeout <= 1'b0;
          rsp_rdata   <= pwrite ? '0 : prdata;
        end else if (timeout_hit) begin
          rsp_valid   <= 1'b1;
          rsp_error   <= 1'b1;
          rsp_timeout <= 1'b1;
          rsp_rdata   <= '0;
        end else begin
          wait_cnt <= wait_cnt + 1'b1;
        end
      end

      if (state == ST_SETUP) begin
        penable  <= 1'b1;
        wait_cnt <= '0;
        state    <= ST_ACCESS;
      end else if (start) begin
        // Load the next transfer; reads drive zero data and strobes.
        paddr   <= head.addr;
        pprot   <= head.prot;
        pwrite  <= head.write;
        pwdata  <= head.write ? head.wdata : '0;
        pstrb   <= head.write ? head.strb  : '0;
        psel    <= head_onehot;
        penable <= 1'b0;
        state   <= ST_SETUP;
      end else if (done) begin
        psel    <= '0;
        penable <= 1'b0;
        state   <= ST_IDLE;
      end else if (dec_err) begin
        rsp_valid   <= 1'b1;
        rsp_error   <= 1'b1;
        rsp_timeout <= 1'b0;
        rsp_rdata   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_apb_master_queued.sv
// Directed bench for apb_master_queued (3 completers, 4-deep queue,
// 16-cycle watchdog). Expected values are hand-computed constants.
module tb_apb_master_queued;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int NS = 3;
  localparam int FD = 4;
  localparam int TO = 16;
  localparam int SW = 2;
  localparam int BW = 4;
  localparam int CW = 3;

  logic          pclk = 1'b0;
  logic          preset_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr = '0;
  logic [2:0]    cmd_prot = '0;
  logic [SW-1:0] cmd_sel = '0;
  logic          cmd_write = 1'b0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [BW-1:0] cmd_strb = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_error;
  logic          rsp_timeout;
  logic [CW-1:0] queue_count;
  logic [AW-1:0] paddr;
  logic [2:0]    pprot;
  logic [NS-1:0] psel;
  logic          penable;
  logic          pwrite;
  logic [DW-1:0] pwdata;
  logic [BW-1:0] pstrb;
  logic          pready = 1'b1;
  logic [DW-1:0] prdata = '0;
  logic          pslverr = 1'b0;

  int checks = 0;
  int errors = 0;

  apb_master_queued #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NO_SLAVES(NS),
    .FIFO_DEPTH(FD), .TIMEOUT(TO)
  ) dut (
    .pclk(pclk), .preset_n(preset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_prot(cmd_prot), .cmd_sel(cmd_sel), .cmd_write(cmd_write),
    .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .rsp_timeout(rsp_timeout), .queue_count(queue_count),
    .paddr(paddr), .pprot(pprot), .psel(psel), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  // Safety net: the directed sequence is fixed-length, this never fires.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "bench watchdog expired");
  end

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [2:0] p, input logic [SW-1:0] s,
                      input logic w, input logic [DW-1:0] d, input logic [BW-1:0] b);
    cmd_addr  = a;
    cmd_prot  = p;
    cmd_sel   = s;
    cmd_write = w;
    cmd_wdata = d;
    cmd_strb  = b;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  logic [AW-1:0] q_addr [4];
  logic [NS-1:0] q_psel [4];

  initial begin
    q_addr = '{10'h020, 10'h030, 10'h040, 10'h050};
    q_psel = '{3'b010, 3'b001, 3'b010, 3'b001};

    // ---------------- reset state ----------------
    step();
    step();
    check("rst_psel", psel, 0);
    check("rst_penable", penable, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_count", queue_count, 0);
    check("rst_paddr", paddr, 0);
    check("rst_pwrite", pwrite, 0);
    preset_n = 1'b1;
    step();

    // ---------------- write, no waits ----------------
    pready = 1'b1;
    push(10'd125, 3'b001, 2'd0, 1'b1, 32'd2772003, 4'b1111);
    check("t1_count_after_push", queue_count, 1);
    check("t1_psel_before", psel, 0);
    step();
    check("t1_setup_psel", psel, 3'b001);
    check("t1_setup_penable", penable, 0);
    check("t1_paddr", paddr, 125);
    check("t1_pprot", pprot, 3'b001);
    check("t1_pwrite", pwrite, 1);
    check("t1_pwdata", pwdata, 2772003);
    check("t1_pstrb", pstrb, 4'b1111);
    check("t1_count_after_pop", queue_count, 0);
    step();
    check("t1_access_psel", psel, 3'b001);
    check("t1_access_penable", penable, 1);
    check("t1_access_no_rsp", rsp_valid, 0);
    step();
    check("t1_rsp_valid", rsp_valid, 1);
    check("t1_rsp_error", rsp_error, 0);
    check("t1_rsp_timeout", rsp_timeout, 0);
    check("t1_rsp_rdata", rsp_rdata, 0);
    check("t1_idle_psel", psel, 0);
    check("t1_idle_penable", penable, 0);
    check("t1_hold_paddr", paddr, 125);
    step();
    check("t1_rsp_pulse_end", rsp_valid, 0);

    // ---------------- read, 3 wait states, slave error ----------------
    pready = 1'b0;
    push(10'd126, 3'b101, 2'd1, 1'b0, 32'hFFFF_FFFF, 4'b1111);
    step();
    check("t2_setup_psel", psel, 3'b010);
    check("t2_pstrb", pstrb, 0);
    check("t2_pwdata", pwdata, 0);
    check("t2_pwrite", pwrite, 0);
    check("t2_pprot", pprot, 3'b101);
    step();
    check("t2_access_penable", penable, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t2_wait_penable", penable, 1);
      check("t2_wait_no_rsp", rsp_valid, 0);
    end
    pready  = 1'b1;
    prdata  = 32'd1234;
    pslverr = 1'b1;
    step();
    check("t2_rsp_valid", rsp_valid, 1);
    check("t2_rsp_rdata", rsp_rdata, 1234);
    check("t2_rsp_error", rsp_error, 1);
    check("t2_rsp_timeout", rsp_timeout, 0);
    check("t2_idle_psel", psel, 0);
    prdata  = '0;
    pslverr = 1'b0;

    // ---------------- queue full and back-to-back ----------------
    pready = 1'b0;
    push(10'h010, 3'b000, 2'd0, 1'b1, 32'hA0A0_0001, 4'b1111);
    step();
    push(q_addr[0], 3'b000, 2'd1, 1'b1, 32'hB0B0_0002, 4'b0011);
    push(q_addr[1], 3'b000, 2'd0, 1'b1, 32'hC0C0_0003, 4'b1100);
    push(q_addr[2], 3'b000, 2'd1, 1'b1, 32'hD0D0_0004, 4'b0001);
    push(q_addr[3], 3'b000, 2'd0, 1'b1, 32'hE0E0_0005, 4'b1000);
    check("t3_full_count", queue_count, 4);
    check("t3_full_ready", cmd_ready, 0);
    push(10'h3FF, 3'b000, 2'd0, 1'b1, 32'hF0F0_0006, 4'b1111);
    check("t3_reject_count", queue_count, 4);
    check("t3_reject_ready", cmd_ready, 0);
    check("t3_stalled_penable", penable, 1);
    pready = 1'b1;
    step();
    check("t3_a_rsp", rsp_valid, 1);
    check("t3_count_after_a", queue_count, 3);
    check("t3_b_pwdata", pwdata, 32'hB0B0_0002);
    for (int k = 0; k < 4; k++) begin
      check("t3_setup_rsp_prev", rsp_valid, 1);
      check("t3_setup_psel", psel, q_psel[k]);
      check("t3_setup_penable", penable, 0);
      check("t3_setup_paddr", paddr, q_addr[k]);
      step();
      check("t3_access_penable", penable, 1);
      check("t3_access_no_rsp", rsp_valid, 0);
      step();
    end
    check("t3_last_rsp", rsp_valid, 1);
    check("t3_last_idle_psel", psel, 0);
    check("t3_last_count", queue_count, 0);
    step();

    // ---------------- watchdog timeout ----------------
    pready = 1'b0;
    prdata = 32'hDEAD_BEEF;
    push(10'h040, 3'b000, 2'd0, 1'b0, 32'h0, 4'b0000);
    push(10'h044, 3'b010, 2'd1, 1'b1, 32'h1234_5678, 4'b1111);
    check("t4_count", queue_count, 1);
    step();
    check("t4_access_penable", penable, 1);
    for (int i = 0; i < 15; i++) begin
      step();
      check("t4_wait_no_rsp", rsp_valid, 0);
      check("t4_wait_penable", penable, 1);
    end
    step();
    check("t4_rsp_valid", rsp_valid, 1);
    check("t4_rsp_error", rsp_error, 1);
    check("t4_rsp_timeout", rsp_timeout, 1);
    check("t4_rsp_rdata", rsp_rdata, 0);
    check("t4_next_psel", psel, 3'b010);
    check("t4_next_penable", penable, 0);
    check("t4_next_paddr", paddr, 10'h044);
    pready = 1'b1;
    prdata = '0;
    step();
    check("t4_next_access", penable, 1);
    step();
    check("t4_next_rsp", rsp_valid, 1);
    check("t4_next_rsp_error", rsp_error, 0);
    check("t4_next_rsp_timeout", rsp_timeout, 0);
    step();

    // ---------------- decode error ----------------
    push(10'h050, 3'b000, 2'd3, 1'b1, 32'h5555_5555, 4'b1111);
    check("t5_count", queue_count, 1);
    step();
    check("t5_rsp_valid", rsp_valid, 1);
    check("t5_rsp_error", rsp_error, 1);
    check("t5_rsp_timeout", rsp_timeout, 0);
    check("t5_rsp_rdata", rsp_rdata, 0);
    check("t5_psel", psel, 0);
    check("t5_count_popped", queue_count, 0);
    step();
    check("t5_rsp_end", rsp_valid, 0);
    check("t5_psel_idle", psel, 0);
    check("t5_penable_idle", penable, 0);

    // ---------------- reset mid-ACCESS with 2 queued ----------------
    pready = 1'b0;
    push(10'h060, 3'b000, 2'd0, 1'b1, 32'h6, 4'b1111);
    push(10'h061, 3'b000, 2'd1, 1'b1, 32'h7, 4'b1111);
    push(10'h062, 3'b000, 2'd0, 1'b1, 32'h8, 4'b1111);
    check("t6_pre_count", queue_count, 2);
    check("t6_pre_penable", penable, 1);
    #2;
    preset_n = 1'b0;
    #1;
    check("t6_rst_psel", psel, 0);
    check("t6_rst_penable", penable, 0);
    check("t6_rst_count", queue_count, 0);
    check("t6_rst_ready", cmd_ready, 1);
    step();
    step();
    preset_n = 1'b1;
    pready   = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("t6_no_rsp", rsp_valid, 0);
      check("t6_no_psel", psel, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
